// File: rtl/piece_sched_if.sv
// Handshake bundle between the move scheduler and its neighbours
// (input debounce, active-piece register, board legality logic).
// The master side drives frame/buttons/board flags; the slave side is
// the scheduler, which drives the move strobes and status.
interface piece_sched_if;
  logic        frame;
  logic        req_left;
  logic        req_right;
  logic        req_rot_r;
  logic        req_rot_l;
  logic        req_down;
  logic [4:0]  can_move;
  logic        spawn_ok;
  logic [4:0]  do_move;
  logic        spawn;
  logic        lock;
  logic        game_over;
  logic        busy;
  logic [15:0] pieces;

  modport master (
    output frame, req_left, req_right, req_rot_r, req_rot_l, req_down,
    output can_move, spawn_ok,
    input  do_move, spawn, lock, game_over, busy, pieces
  );

  modport slave (
    input  frame, req_left, req_right, req_rot_r, req_rot_l, req_down,
    input  can_move, spawn_ok,
    output do_move, spawn, lock, game_over, busy, pieces
  );
endinterface

// File: rtl/piece_sched.sv
// Per-frame Tetris move scheduler: one player action plus one gravity
// step per frame, lock delay, spawn requests and game-over detection.
// Bit order of can_move/do_move: {left, right, rot_r, rot_l, down}.
// Optional feature: define PIECE_SCHED_AUTOREPEAT_EN to build DAS/ARR
// auto-repeat for held left/right; without it lateral moves are
// edge-triggered only and the repeat counters do not exist.
module piece_sched #(
  parameter int GRAVITY_FRAMES   = 48,
  parameter int SOFT_DROP_FRAMES = 2,
  parameter int LOCK_FRAMES      = 30,
  parameter int DAS_FRAMES       = 16,
  parameter int ARR_FRAMES       = 6
) (
  input logic         Clk,
  input logic         Reset,
  piece_sched_if.slave bus
);

  // All frame counters are 8 bits wide; reject values they cannot hold.
  if (GRAVITY_FRAMES > 255 || SOFT_DROP_FRAMES > 255 || LOCK_FRAMES > 255 ||
      DAS_FRAMES > 255 || ARR_FRAMES > 255) begin : g_param_range
    $error("piece_sched: frame parameters must fit 8-bit counters");
  end

  localparam logic [7:0] GRAV_P = 8'(GRAVITY_FRAMES);
  localparam logic [7:0] SOFT_P = 8'(SOFT_DROP_FRAMES);
  localparam logic [7:0] LOCK_P = 8'(LOCK_FRAMES);

  typedef enum logic [3:0] {
    SPAWN, SPAWN_CHK, WAIT, EVAL_ACT, SETTLE_A, EVAL_DOWN, SETTLE_D, LOCK, OVER
  } state_t;

  state_t      state_q, state_d;
  logic        sub_q;        // second-cycle marker for the 2-cycle states
  logic [7:0]  grav_q;
  logic [7:0]  lock_cnt_q;
  logic [15:0] pieces_q;
  logic [3:0]  prev_q;       // {left, right, rot_r, rot_l} at last EVAL_ACT

  logic [3:0]  req;
  logic [3:0]  rise;
  logic        lat_l, lat_r;
  logic        rep_l, rep_r;
  logic [4:0]  act_sel, act_fire;
  logic [7:0]  period;
  logic        grav_due;
  logic [7:0]  lock_inc;
  logic [4:0]  mv_c;
  logic        spawn_c, lock_c;

  assign req      = {bus.req_left, bus.req_right, bus.req_rot_r, bus.req_rot_l};
  assign period   = bus.req_down ? SOFT_P : GRAV_P;
  assign grav_due = (grav_q >= period);
  assign lock_inc = (lock_cnt_q == 8'hFF) ? 8'hFF : lock_cnt_q + 8'd1;

`ifdef PIECE_SCHED_AUTOREPEAT_EN
  localparam logic [7:0] DAS_P = 8'(DAS_FRAMES);
  localparam logic [7:0] ARR_P = 8'(ARR_FRAMES);

  logic [1:0] dir_q, held_dir;   // {left, right}, only one may be set
  logic [7:0] das_q, arr_q, das_n, arr_n;
  logic       rep;

  assign held_dir = {bus.req_left & ~bus.req_right, bus.req_right & ~bus.req_left};

  // Held-direction timing: DAS delay first, then a repeat every ARR frames.
  always_comb begin
    rep   = 1'b0;
    das_n = '0;
    arr_n = '0;
    if (held_dir != 2'b00 && held_dir == dir_q) begin
      if (das_q < DAS_P) begin
        das_n = das_q + 8'd1;
        rep   = (das_n >= DAS_P);
      end else begin
        das_n = das_q;
        arr_n = arr_q + 8'd1;
        rep   = (arr_n >= ARR_P);
        if (rep) arr_n = '0;
      end
    end
  end

  assign rep_l = rep & held_dir[1];
  assign rep_r = rep & held_dir[0];

  // Repeat counters advance once per evaluated frame and restart on spawn.
  always_ff @(posedge Clk) begin
    if (Reset || state_q == SPAWN) begin
      dir_q <= '0;
      das_q <= '0;
      arr_q <= '0;
    end else if (state_q == EVAL_ACT) begin
      dir_q <= held_dir;
      das_q <= das_n;
      arr_q <= arr_n;
    end
  end
`else
  assign rep_l = 1'b0;
  assign rep_r = 1'b0;
`endif

  // Pick this frame's single player action by priority, then gate by legality.
  always_comb begin
    rise    = req & ~prev_q;
    lat_l   = rise[3] | rep_l;
    lat_r   = rise[2] | rep_r;
    act_sel = '0;
    if (rise[1])              act_sel = 5'b00100;
    else if (rise[0])         act_sel = 5'b00010;
    else if (lat_l && !lat_r) act_sel = 5'b10000;
    else if (lat_r && !lat_l) act_sel = 5'b01000;
    act_fire = act_sel & bus.can_move;
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d = state_q;
    mv_c    = '0;
    spawn_c = 1'b0;
    lock_c  = 1'b0;
    unique case (state_q)
      SPAWN: begin
        spawn_c = 1'b1;
        state_d = SPAWN_CHK;
      end
      SPAWN_CHK: if (sub_q) state_d = bus.spawn_ok ? WAIT : OVER;
      WAIT:      if (bus.frame) state_d = EVAL_ACT;
      EVAL_ACT: begin
        mv_c    = act_fire;
        state_d = (act_fire != 5'b0) ? SETTLE_A : EVAL_DOWN;
      end
      SETTLE_A:  if (sub_q) state_d = EVAL_DOWN;
      EVAL_DOWN: begin
        if (bus.can_move[0]) begin
          if (grav_due) begin
            mv_c    = 5'b00001;
            state_d = SETTLE_D;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = (lock_inc >= LOCK_P) ? LOCK : WAIT;
        end
      end
      SETTLE_D:  if (sub_q) state_d = WAIT;
      LOCK: begin
        lock_c  = 1'b1;
        state_d = SPAWN;
      end
      OVER:      state_d = OVER;
      default:   state_d = SPAWN;
    endcase
  end

  // State register plus the phase bit used by the 2-cycle states.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= SPAWN;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= (state_d == state_q) ? ~sub_q : 1'b0;
    end
  end

  // Gravity, lock-delay and edge-history bookkeeping; all restart per piece.
  always_ff @(posedge Clk) begin
    if (Reset || state_q == SPAWN) begin
      grav_q     <= '0;
      lock_cnt_q <= '0;
      prev_q     <= '0;
    end else begin
      if (state_q == WAIT && bus.frame && grav_q != 8'hFF)
        grav_q <= grav_q + 8'd1;
      else if (state_q == EVAL_DOWN && bus.can_move[0] && grav_due)
        grav_q <= '0;
      if (state_q == EVAL_DOWN)
        lock_cnt_q <= bus.can_move[0] ? 8'd0 : lock_inc;
      if (state_q == EVAL_ACT)
        prev_q <= req;
    end
  end

  // Locked-piece counter, saturating.
  always_ff @(posedge Clk) begin
    if (Reset)
      pieces_q <= '0;
    else if (state_q == LOCK && pieces_q != 16'hFFFF)
      pieces_q <= pieces_q + 16'd1;
  end

  assign bus.do_move   = Reset ? 5'b0 : mv_c;
  assign bus.spawn     = ~Reset & spawn_c;
  assign bus.lock      = ~Reset & lock_c;
  assign bus.game_over = ~Reset & (state_q == OVER);
  assign bus.busy      = ~Reset & (state_q != WAIT) & (state_q != OVER);
  assign bus.pieces    = Reset ? 16'h0 : pieces_q;

endmodule

// File: doc/piece_sched.md
# piece_sched

Per-frame move scheduler for the Tetris board. Once per 60 Hz frame it turns held player inputs and a gravity timer into at most one player action and one downward step, each gated by the board's `can_move` flags. It also runs the lock delay, requests piece spawns and detects game over. It sits between input debounce and the active-piece register / board, and issues one-hot move strobes that the piece register uses to adopt a candidate position.

## Interface
Parameters:
- `GRAVITY_FRAMES`, default 48: frames per gravity step with no soft drop.
- `SOFT_DROP_FRAMES`, default 2: frames per gravity step while `req_down` is held.
- `LOCK_FRAMES`, default 30: consecutive blocked frames before the piece locks.
- `DAS_FRAMES`, default 16: auto-repeat initial delay. Used only with the macro.
- `ARR_FRAMES`, default 6: auto-repeat period. Used only with the macro.

Ports:
- `Clk`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high.
- `frame`  in  1  one-cycle pulse per game frame. Pulses are ≥8 cycles apart.
- `req_left`, `req_right`, `req_rot_r`, `req_rot_l`, `req_down`  in  1 each  debounced button levels.
- `can_move`  in  5  board legality flags: {left, right, rot_r, rot_l, down}.
- `spawn_ok`  in  1  spawn position is free. Valid 2 cycles after `spawn`.
- `do_move`  out  5  one-hot, one-cycle strobe. Same bit order as `can_move`.
- `spawn`  out  1  one-cycle request to load a new piece.
- `lock`  out  1  one-cycle pulse: the current piece is frozen.
- `game_over`  out  1  sticky until `Reset`.
- `busy`  out  1  high in every state except WAIT and OVER.
- `pieces`  out  16  count of locked pieces. Saturates at 0xFFFF.

## Operation
States: SPAWN, SPAWN_CHK, WAIT, EVAL_ACT, SETTLE_A, EVAL_DOWN, SETTLE_D, LOCK, OVER.
- **SPAWN** (1 cycle): `spawn`=1. Clears the gravity counter, the lock counter and the edge history. Next state SPAWN_CHK.
- **SPAWN_CHK** (2 cycles): on the second cycle, `spawn_ok`=0 → OVER; otherwise → WAIT.
- **WAIT**: a `frame` pulse increments the gravity counter (saturating) and moves to EVAL_ACT.
- **EVAL_ACT** (1 cycle):
  - Rising edges are computed against the request levels sampled at the previous EVAL_ACT.
  - Priority: rot_r edge > rot_l edge > left edge > right edge.
  - The winner fires `do_move[bit]` only if `can_move[bit]`=1, then → SETTLE_A.
  - If there is no winner or the move is illegal, go directly to EVAL_DOWN.
  - Left and right edges in the same frame cancel each other.
- **SETTLE_A** (2 cycles): the piece register and board update. `can_move` is not sampled. Next state EVAL_DOWN.
- **EVAL_DOWN** (1 cycle). Gravity is due when the counter ≥ period; the period is `SOFT_DROP_FRAMES` if `req_down` is held, else `GRAVITY_FRAMES`.
  - `can_move[0]`=1: clear the lock counter. If due, fire `do_move[0]`, clear the gravity counter and → SETTLE_D; else → WAIT.
  - `can_move[0]`=0: increment the lock counter. If it reaches `LOCK_FRAMES` → LOCK; else → WAIT.
  - A successful rotate or lateral move this frame does not reset the lock counter.
- **SETTLE_D** (2 cycles): next state WAIT.
- **LOCK** (1 cycle): `lock`=1 and `pieces` increments. Next state SPAWN.
- **OVER**: `game_over`=1. All strobes stay 0 and `frame` is ignored until `Reset`.

Invariants:
- At most one `do_move` bit is set in any cycle.
- At most two `do_move` strobes occur per frame.
- A `frame` pulse that arrives outside WAIT is dropped.

## Timing
- In the cycle `Reset` is high, all outputs are 0 and the state is forced to SPAWN.
- `spawn`=1 in the first cycle after `Reset` deasserts.
- A reset mid-operation (in any state) takes effect the same way; there is no pending strobe afterwards.
- Latency from `frame` to the action strobe: 1 cycle (`do_move` asserted in EVAL_ACT).
- Latency from `frame` to the gravity strobe:
  - 4 cycles if an action fired this frame.
  - 2 cycles if no action fired.
- The counters are 8-bit. Their compare is ≥, so a parameter change at elaboration never deadlocks.
- A frame that ends in LOCK emits `spawn` 1 cycle after `lock`.

## Configuration
- `PIECE_SCHED_AUTOREPEAT_EN` defined:
  - A held left or right also counts as an "edge" once it has been held `DAS_FRAMES` frames.
  - After that it repeats every `ARR_FRAMES` frames.
  - The repeat counter resets on release or direction change.
  - Rotations never repeat.
- Undefined: lateral moves fire on rising edges only, and the DAS/ARR counters are not built.

## Test plan
- **Reset and spawn:** Reset for 3 cycles, `spawn_ok`=1 → `spawn` pulses in the 1st post-reset cycle, then WAIT; `game_over`=0, `pieces`=0.
- **Gravity:** `GRAVITY_FRAMES`=4, `can_move`=5'b11111, no buttons → `do_move`=5'b00001 on every 4th frame, 2 cycles after `frame`.
- **Priority:** `req_rot_r` and `req_left` rise together, `can_move`=5'b11111 → only `do_move`=5'b00100 that frame. Next frame, with both still held → no action (edge-only).
- **Lock:** `LOCK_FRAMES`=3, `can_move[0]`=0 → `lock` on the 3rd frame, `pieces`=1, `spawn` the next cycle.
- **Game over:** `spawn_ok`=0 at SPAWN_CHK → `game_over`=1 and stays 1 through 10 frames with buttons toggling; `do_move` stays 0. Reset → `game_over`=0.
- **Autorepeat (macro on):** DAS=16, ARR=6, `req_right` held 30 frames → `do_move[3]` on frames 1, 17, 23, 29.
